// File: rtl/ghash_mul_scheduler.sv
// GHASH sequencer: folds each 128-bit block into Y = (Y ^ X) * H by driving a shared
// fixed-latency GF(2^128) multiplier, and reports the final Y as the tag hash.
module ghash_mul_scheduler #(
   parameter int NB_DATA     = 128,
   parameter int MUL_LATENCY = 1,
   parameter int NB_CNT      = 4
) (
   input  logic               i_clock,
   input  logic               i_reset,
   input  logic               i_start,
   input  logic [NB_DATA-1:0] i_hkey,
   input  logic [NB_DATA-1:0] i_data,
   input  logic               i_valid,
   input  logic               i_last,
   output logic               o_ready,
   output logic [NB_DATA-1:0] o_mul_x,
   output logic [NB_DATA-1:0] o_mul_y,
   output logic               o_mul_valid,
   input  logic [NB_DATA-1:0] i_mul_z,
   output logic [NB_DATA-1:0] o_ghash,
   output logic               o_ghash_valid,
   output logic               o_busy
);

   generate
      if (NB_DATA != 128 || MUL_LATENCY < 1 || MUL_LATENCY > 15 ||
          (2 ** NB_CNT) <= MUL_LATENCY) begin : gBadConfig
         $error("ghash_mul_scheduler: illegal parameter combination");
      end
   endgenerate

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_WAIT = 2'd1,
      S_MULT = 2'd2
   } state_t;

   localparam logic [NB_CNT-1:0] LP_CNT_LOAD = NB_CNT'(MUL_LATENCY);
   localparam logic [NB_CNT-1:0] LP_CNT_ONE  = NB_CNT'(1);

   state_t               r_state;
   state_t               w_next_state;
   logic [NB_DATA-1:0]   r_y;
   logic [NB_DATA-1:0]   r_h;
   logic [NB_DATA-1:0]   r_mul_x;
   logic [NB_DATA-1:0]   r_mul_y;
   logic                 r_mul_valid;
   logic [NB_DATA-1:0]   r_ghash;
   logic                 r_ghash_valid;
   logic                 r_ready;
   logic                 r_busy;
   logic [NB_CNT-1:0]    r_cnt;
   logic                 r_last;
   logic                 w_accept;
   logic                 w_sample;

   // i_start outranks everything, so neither an accept nor a product sample may coincide with it.
   assign w_accept = i_valid & r_ready & (r_state == S_WAIT) & ~i_start;
   assign w_sample = (r_state == S_MULT) & (r_cnt == LP_CNT_ONE) & ~i_start;

   always_comb begin
      w_next_state = r_state;
      if (i_start) begin
         w_next_state = S_WAIT;
      end else begin
         case (r_state)
            S_IDLE:  w_next_state = S_IDLE;
            S_WAIT:  if (w_accept) w_next_state = S_MULT;
            S_MULT:  if (w_sample) w_next_state = r_last ? S_IDLE : S_WAIT;
            default: w_next_state = S_IDLE;
         endcase
      end
   end

   // Handshake flags are registered from the next state so they are glitch-free at the port.
   always_ff @(posedge i_clock or posedge i_reset) begin
      if (i_reset) begin
         r_state <= S_IDLE;
         r_ready <= 1'b0;
         r_busy  <= 1'b0;
      end else begin
         r_state <= w_next_state;
         r_ready <= (w_next_state == S_WAIT);
         r_busy  <= (w_next_state != S_IDLE);
      end
   end

   always_ff @(posedge i_clock or posedge i_reset) begin
      if (i_reset) begin
         r_y           <= '0;
         r_h           <= '0;
         r_mul_x       <= '0;
         r_mul_y       <= '0;
         r_mul_valid   <= 1'b0;
         r_ghash       <= '0;
         r_ghash_valid <= 1'b0;
         r_cnt         <= '0;
         r_last        <= 1'b0;
      end else begin
         r_mul_valid   <= 1'b0;
         r_ghash_valid <= 1'b0;
         if (i_start) begin
            r_y     <= '0;
            r_h     <= i_hkey;
            r_mul_y <= i_hkey;
            r_last  <= 1'b0;
            r_cnt   <= '0;
         end else if (w_accept) begin
            r_mul_x     <= r_y ^ i_data;
            r_mul_y     <= r_h;
            r_mul_valid <= 1'b1;
            r_last      <= i_last;
            r_cnt       <= LP_CNT_LOAD;
         end else if (r_state == S_MULT) begin
            r_cnt <= r_cnt - LP_CNT_ONE;
            if (w_sample) begin
               r_y <= i_mul_z;
               if (r_last) begin
                  r_ghash       <= i_mul_z;
                  r_ghash_valid <= 1'b1;
               end
            end
         end
      end
   end

   assign o_ready       = r_ready;
   assign o_mul_x       = r_mul_x;
   assign o_mul_y       = r_mul_y;
   assign o_mul_valid   = r_mul_valid;
   assign o_ghash       = r_ghash;
   assign o_ghash_valid = r_ghash_valid;
   assign o_busy        = r_busy;

endmodule

// File: tb/tb_ghash_mul_scheduler.sv
// Scoreboard bench for ghash_mul_scheduler: a main latency-1 instance for directed cases,
// a latency-3 instance for mid-multiply reset, and a latency sweep over {1,4,15}.
module tb_ghash_mul_scheduler;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   int           nChecks = 0;
   int           nFail = 0;
   int           cycleCnt = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cycleCnt <= cycleCnt + 1;

   // Reference GCM multiply (bit-reflected, R = 0xE1 || 0^120).
   function automatic logic [127:0] gfmul(input logic [127:0] a, input logic [127:0] b);
      logic [127:0] z;
      logic [127:0] v;
      z = '0;
      v = b;
      for (int i = 0; i < 128; i++) begin
         if (a[127-i]) z = z ^ v;
         if (v[0]) v = (v >> 1) ^ {8'hE1, 120'h0};
         else      v = v >> 1;
      end
      return z;
   endfunction

   function automatic logic [127:0] rand128();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
      nChecks++;
      if (act !== exp) begin
         nFail++;
         $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // ---------------- main instance, MUL_LATENCY = 1 ----------------
   logic         start = 1'b0, valid = 1'b0, last = 1'b0;
   logic [127:0] hkey = '0, data = '0;
   logic         ready, mulValid, ghashValid, busy;
   logic [127:0] mulX, mulY, mulZ, ghash;
   logic [127:0] expMulX[$];
   logic [127:0] expMulY[$];
   logic [127:0] expGhash[$];
   logic [127:0] modelY = '0, modelH = '0;
   int           lastAccept = 0;
   int           mulValidCnt = 0;
   int           ghashValidCnt = 0;

   ghash_mul_scheduler #(.NB_DATA(128), .MUL_LATENCY(1), .NB_CNT(4)) dut (
      .i_clock(clk), .i_reset(rst), .i_start(start), .i_hkey(hkey), .i_data(data),
      .i_valid(valid), .i_last(last), .o_ready(ready), .o_mul_x(mulX), .o_mul_y(mulY),
      .o_mul_valid(mulValid), .i_mul_z(mulZ), .o_ghash(ghash), .o_ghash_valid(ghashValid),
      .o_busy(busy)
   );

   assign mulZ = gfmul(mulX, mulY);

   always @(negedge clk) begin
      if (!rst) begin
         if (start && valid) checkOutput("protocolStartWithValid", 1, 0);
         if (mulValid) begin
            mulValidCnt <= mulValidCnt + 1;
            checkOutput("readyInMult", ready, 0);
            if (expMulX.size() == 0) checkOutput("unexpectedMulValid", 1, 0);
            else begin
               checkOutput("mulX", mulX, expMulX.pop_front());
               checkOutput("mulY", mulY, expMulY.pop_front());
            end
         end
         if (ghashValid) begin
            ghashValidCnt <= ghashValidCnt + 1;
            if (expGhash.size() == 0) checkOutput("unexpectedGhashValid", 1, 0);
            else begin
               checkOutput("ghash", ghash, expGhash.pop_front());
               checkOutput("ghashLatency", cycleCnt + 1 - lastAccept, 2);
            end
         end
      end
   end

   task automatic doStart(input logic [127:0] h);
      start = 1'b1;
      hkey  = h;
      @(posedge clk); #1;
      start  = 1'b0;
      modelY = '0;
      modelH = h;
   endtask

   task automatic applyStimulus(input logic [127:0] d, input bit isLast, input bit holdAfter);
      int cnt;
      valid = 1'b1;
      data  = d;
      last  = isLast;
      cnt   = 0;
      do begin
         @(negedge clk);
         cnt++;
      end while (!ready && cnt < 64);
      if (!ready) checkOutput("acceptTimeout", 1, 0);
      lastAccept = cycleCnt + 1;
      expMulX.push_back(modelY ^ d);
      expMulY.push_back(modelH);
      modelY = gfmul(modelY ^ d, modelH);
      if (isLast) expGhash.push_back(modelY);
      @(posedge clk); #1;
      if (holdAfter) begin
         @(posedge clk); #1;
      end
      valid = 1'b0;
      last  = 1'b0;
   endtask

   task automatic waitResult();
      int cnt;
      cnt = 0;
      while (expGhash.size() != 0 && cnt < 64) begin
         @(posedge clk);
         cnt++;
      end
      if (expGhash.size() != 0) checkOutput("resultTimeout", 1, 0);
      @(posedge clk); #1;
   endtask

   // ---------------- latency-3 instance for mid-multiply reset ----------------
   logic         tRst = 1'b1, tStart = 1'b0, tValid = 1'b0, tLast = 1'b0;
   logic [127:0] tHkey = '0, tData = '0;
   logic         tReady, tMulValid, tGhashValid, tBusy;
   logic [127:0] tMulX, tMulY, tMulZ, tGhash;
   bit           t3Done = 1'b0;

   ghash_mul_scheduler #(.NB_DATA(128), .MUL_LATENCY(3), .NB_CNT(4)) dut3 (
      .i_clock(clk), .i_reset(tRst), .i_start(tStart), .i_hkey(tHkey), .i_data(tData),
      .i_valid(tValid), .i_last(tLast), .o_ready(tReady), .o_mul_x(tMulX), .o_mul_y(tMulY),
      .o_mul_valid(tMulValid), .i_mul_z(tMulZ), .o_ghash(tGhash), .o_ghash_valid(tGhashValid),
      .o_busy(tBusy)
   );

   assign tMulZ = gfmul(tMulX, tMulY);

   initial begin
      int           cnt;
      bit           sawValid, sawReady;
      logic [127:0] h, x;
      h = 128'h0123456789abcdef_fedcba9876543210;
      x = 128'hdeadbeef00112233_445566778899aabb;
      wait (!rst);
      @(posedge clk); #1;
      tRst = 1'b0;
      @(posedge clk); #1;
      tStart = 1'b1; tHkey = h;
      @(posedge clk); #1;
      tStart = 1'b0;
      tData = x; tLast = 1'b1; tValid = 1'b1; cnt = 0;
      do begin @(negedge clk); cnt++; end while (!tReady && cnt < 32);
      @(posedge clk); #1;
      tValid = 1'b0;
      cnt = 0;
      while (!tGhashValid && cnt < 32) begin @(negedge clk); cnt++; end
      checkOutput("rst3FirstHash", tGhash, gfmul(x, h));
      @(posedge clk); #1;
      tStart = 1'b1; tHkey = ~h;
      @(posedge clk); #1;
      tStart = 1'b0;
      tData = ~x; tValid = 1'b1; cnt = 0;
      do begin @(negedge clk); cnt++; end while (!tReady && cnt < 32);
      @(posedge clk); #1;
      tValid = 1'b0; tLast = 1'b0;
      @(posedge clk); #1;
      checkOutput("rst3BusyBeforeReset", tBusy, 1);
      tRst = 1'b1;
      #1;
      checkOutput("rst3Ready", tReady, 0);
      checkOutput("rst3MulValid", tMulValid, 0);
      checkOutput("rst3GhashValid", tGhashValid, 0);
      checkOutput("rst3Busy", tBusy, 0);
      checkOutput("rst3MulX", tMulX, 0);
      checkOutput("rst3MulY", tMulY, 0);
      checkOutput("rst3Ghash", tGhash, 0);
      @(posedge clk); #1;
      tRst = 1'b0;
      sawValid = 1'b0; sawReady = 1'b0;
      repeat (12) begin
         @(negedge clk);
         if (tGhashValid) sawValid = 1'b1;
         if (tReady) sawReady = 1'b1;
      end
      checkOutput("rst3NoGhashAfterReset", sawValid, 0);
      checkOutput("rst3ReadyBeforeStart", sawReady, 0);
      @(posedge clk); #1;
      tStart = 1'b1;
      @(posedge clk); #1;
      tStart = 1'b0;
      @(negedge clk);
      checkOutput("rst3ReadyAfterStart", tReady, 1);
      t3Done = 1'b1;
   end

   // ---------------- latency sweep, i_valid held high ----------------
   for (genvar g = 0; g < 3; g++) begin : gSweep
      localparam int L   = (g == 0) ? 1 : ((g == 1) ? 4 : 15);
      localparam int IDX = (L >= 2) ? L - 2 : 0;
      logic         sStart = 1'b0, sValid = 1'b0, sLast = 1'b0;
      logic [127:0] sHkey = '0, sData = '0;
      logic         sReady, sMulValid, sGhashValid, sBusy;
      logic [127:0] sMulX, sMulY, sMulZ, sGhash;
      logic [127:0] pipe [0:14];
      logic [127:0] expQ[$];
      int           lastAcc = 0;
      bit           done = 1'b0;

      ghash_mul_scheduler #(.NB_DATA(128), .MUL_LATENCY(L), .NB_CNT(4)) dutS (
         .i_clock(clk), .i_reset(rst), .i_start(sStart), .i_hkey(sHkey), .i_data(sData),
         .i_valid(sValid), .i_last(sLast), .o_ready(sReady), .o_mul_x(sMulX), .o_mul_y(sMulY),
         .o_mul_valid(sMulValid), .i_mul_z(sMulZ), .o_ghash(sGhash), .o_ghash_valid(sGhashValid),
         .o_busy(sBusy)
      );

      // Product becomes visible exactly L cycles after the operands change; stale before that.
      always @(posedge clk) begin
         pipe[0] <= gfmul(sMulX, sMulY);
         for (int k = 1; k < 15; k++) pipe[k] <= pipe[k-1];
      end
      assign sMulZ = (L == 1) ? gfmul(sMulX, sMulY) : pipe[IDX];

      always @(negedge clk) begin
         if (!rst && sGhashValid) begin
            if (expQ.size() == 0) checkOutput($sformatf("sweepL%0dUnexpected", L), 1, 0);
            else begin
               checkOutput($sformatf("sweepL%0dGhash", L), sGhash, expQ.pop_front());
               checkOutput($sformatf("sweepL%0dLatency", L), cycleCnt + 1 - lastAcc, L + 1);
            end
         end
      end

      initial begin
         logic [127:0] y, h, x;
         int           prevAcc, cnt;
         prevAcc = 0;
         wait (!rst);
         @(posedge clk); #1;
         h = rand128();
         sStart = 1'b1; sHkey = h;
         @(posedge clk); #1;
         sStart = 1'b0;
         y = '0;
         for (int k = 0; k < 5; k++) begin
            x = rand128();
            sData = x; sLast = (k == 4); sValid = 1'b1; cnt = 0;
            do begin @(negedge clk); cnt++; end while (!sReady && cnt < 64);
            if (!sReady) checkOutput($sformatf("sweepL%0dAcceptTimeout", L), 1, 0);
            if (k > 0) checkOutput($sformatf("sweepL%0dInterval", L), cycleCnt + 1 - prevAcc, L + 1);
            prevAcc = cycleCnt + 1;
            lastAcc = prevAcc;
            y = gfmul(y ^ x, h);
            if (k == 4) expQ.push_back(y);
            @(posedge clk); #1;
         end
         sValid = 1'b0; sLast = 1'b0;
         cnt = 0;
         while (expQ.size() != 0 && cnt < 64) begin @(posedge clk); cnt++; end
         if (expQ.size() != 0) checkOutput($sformatf("sweepL%0dResultTimeout", L), 1, 0);
         done = 1'b1;
      end
   end

   // ---------------- main sequence ----------------
   initial begin
      int cnt, mvBase, gvBase;
      @(negedge clk);
      checkOutput("resetReady", ready, 0);
      checkOutput("resetMulValid", mulValid, 0);
      checkOutput("resetGhashValid", ghashValid, 0);
      checkOutput("resetBusy", busy, 0);
      checkOutput("resetMulX", mulX, 0);
      checkOutput("resetMulY", mulY, 0);
      checkOutput("resetGhash", ghash, 0);
      @(posedge clk); #1;
      rst = 1'b0;

      // i_valid without i_start must be ignored in IDLE.
      valid = 1'b1; data = {16{8'h5A}};
      repeat (3) begin
         @(negedge clk);
         checkOutput("idleReady", ready, 0);
      end
      @(posedge clk); #1;
      valid = 1'b0;

      $display("[TB] identity key");
      mvBase = mulValidCnt; gvBase = ghashValidCnt;
      doStart({1'b1, 127'b0});
      applyStimulus({16{8'h11}}, 1'b0, 1'b0);
      applyStimulus({16{8'h22}}, 1'b0, 1'b0);
      applyStimulus({16{8'h44}}, 1'b1, 1'b0);
      waitResult();
      checkOutput("identityGhash", ghash, {16{8'h77}});
      checkOutput("identityMulValidCount", mulValidCnt - mvBase, 3);
      checkOutput("identityGhashValidCount", ghashValidCnt - gvBase, 1);

      $display("[TB] zero key");
      doStart('0);
      applyStimulus(128'h0f1e2d3c4b5a6978_8796a5b4c3d2e1f0, 1'b0, 1'b0);
      applyStimulus(128'hcafebabe12345678_9abcdef001020304, 1'b0, 1'b1);
      applyStimulus(128'h0000000000000001_8000000000000000, 1'b0, 1'b0);
      applyStimulus(128'h0000000000000000_0000000000000400, 1'b1, 1'b0);
      waitResult();
      checkOutput("zeroKeyGhash", ghash, 0);
      checkOutput("zeroKeyLastMulX", mulX, 128'h0000000000000000_0000000000000400);

      $display("[TB] abort");
      gvBase = ghashValidCnt;
      doStart(128'h66e94bd4ef8a2c3b_884cfa59ca342b2e);
      applyStimulus(rand128(), 1'b0, 1'b0);
      applyStimulus(rand128(), 1'b0, 1'b0);
      applyStimulus(rand128(), 1'b1, 1'b0);
      doStart(128'hb83b533708bf535d_0aa6e52980d53b78);
      void'(expGhash.pop_back());
      applyStimulus(128'h42831ec221777424_4b7221b784d0d49c, 1'b1, 1'b0);
      waitResult();
      checkOutput("abortGhashValidCount", ghashValidCnt - gvBase, 1);
      checkOutput("abortGhash", ghash,
                  gfmul(128'h42831ec221777424_4b7221b784d0d49c, 128'hb83b533708bf535d_0aa6e52980d53b78));

      $display("[TB] backpressure");
      mvBase = mulValidCnt;
      doStart(rand128());
      for (int k = 0; k < 6; k++) begin
         repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
         applyStimulus(rand128(), k == 5, $urandom_range(0, 1) == 1);
      end
      waitResult();
      checkOutput("backpressureMulValidCount", mulValidCnt - mvBase, 6);

      cnt = 0;
      while (!(t3Done && gSweep[0].done && gSweep[1].done && gSweep[2].done) && cnt < 3000) begin
         @(posedge clk);
         cnt++;
      end
      checkOutput("allProcessesDone", {gSweep[0].done, gSweep[1].done, gSweep[2].done, t3Done}, 4'hF);
      checkOutput("mulXQueueEmpty", expMulX.size(), 0);
      checkOutput("ghashQueueEmpty", expGhash.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
      $finish;
   end

   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: simulation did not finish, checks=%0d", nChecks);
      $fatal(1, "[TB] watchdog expired");
   end

endmodule
